muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide sequencer for the execute stage. Accepts one M-extension operation per start pulse, captures operands, runs a 32-step shift-add or restoring-divide loop, applies sign correction and handles special cases. Produces a 32-bit result with a one-cycle done pulse. While busy, the pipeline stalls and the writeback 3-way select steers to this unit's result.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  operand A; sampled with start
- rs2  in  32  operand B; sampled with start
- flush  in  1  abort the current operation
- busy  out  1  operation in progress; the pipeline stalls on it
- done  out  1  one-cycle pulse; result valid
- result  out  32  operation result; held until the next accepted start

## Operation
- Operand signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - MUL: sign irrelevant; computed as signed.
- On accept, latch:
  - funct3;
  - the magnitudes of rs1 and rs2;
  - the result-negate flag:
    - multiply: sign(a) XOR sign(b);
    - DIV: sign(a) XOR sign(b);
    - REM: sign(a).
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE → DONE when start is accepted and the operation is a special case; the special result is loaded directly.
  - IDLE → CALC when start is accepted otherwise; the step counter is cleared.
  - CALC: one step per cycle; → FIX after step 32 (counter 31 → wrap).
  - FIX: apply two's-complement negation if the flag is set; select the output:
    - MUL: low 32 bits of the product;
    - MULH*: high 32 bits of the product;
    - DIV*: quotient;
    - REM*: remainder.
    - Then → DONE.
  - DONE: done=1 for exactly one cycle.
    - → CALC or DONE if start is present (back-to-back accept).
    - Otherwise → IDLE.
- Multiply step: 64-bit accumulator; if multiplier bit i is set, add the multiplicand shifted left by i.
- Divide step (restoring):
  - shift the remainder left and bring in the next dividend bit;
  - trial-subtract the divisor;
  - set the quotient bit if the result is non-negative.
- Special cases, 1-cycle path:
  - divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - DIV overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Start in CALC/FIX is ignored.
- flush in CALC/FIX/DONE → IDLE on the next edge. No done is produced (any pending done is suppressed) and result is not updated.
- flush and start in the same IDLE cycle: flush wins; start is dropped.

## Timing
- Reset values: busy=0, done=0, result=0, state=IDLE, counter=0. Reset mid-operation aborts immediately (asynchronous).
- busy is a registered output, high in CALC and FIX. It goes high the cycle after start is accepted and low in the DONE cycle.
- Normal latency: start accepted at edge k; done high in the cycle following edge k+34 (32 CALC + 1 FIX + entry into DONE).
- Special-case latency: done high in the cycle following edge k+1.
- result changes only on the edge entering DONE.
- Back-to-back: start in the DONE cycle is accepted; no IDLE bubble.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package rv32m_pkg holds:
  - funct3 encodings (MUL … REMU);
  - FSM state encoding (2 bits);
  - the special-case constants 0xFFFFFFFF and 0x80000000.
- One sub-module is natural: muldiv_step, a combinational single-iteration datapath.
  - Inputs: mode, accumulator/remainder, operand, bit index.
  - Outputs: next accumulator/remainder and quotient bit.
- The FSM, counter, sign logic and output register stay in muldiv_unit.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB; done exactly 34 edges after start; busy high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases (done 1 edge after start, busy never high):
  - DIVU x/0 → 0xFFFFFFFF;
  - REM 0x1234/0 → 0x1234;
  - DIV 0x80000000/−1 → 0x80000000;
  - REM 0x80000000/−1 → 0.
- flush at CALC step 10 → IDLE next edge; no done; result keeps the previous value. start during CALC is ignored. rst_n low mid-CALC → all outputs 0 immediately.
- Back-to-back ops:
  - start in the DONE cycle is accepted; the second op's done arrives 34 edges later.
  - flush+start in IDLE → nothing is accepted.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings, sequencer
// state encoding and the fixed results of the divide special cases.
package rv32m_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN);

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

   // Two's-complement negate when n is set.
   function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
      return n ? (~x + XLEN'(1)) : x;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the multiply/divide loop (purely combinational).
//   is_div    : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i     : product accumulator (mul) or partial remainder in [31:0] (div)
//   operand_i : multiplicand (mul) or divisor (div), both as magnitudes
//   src_i     : multiplier (mul) or dividend (div)
//   bit_idx   : bit of src_i consumed by this step
//   acc_o     : next accumulator / remainder
//   q_bit     : quotient bit produced by a divide step
module muldiv_step
   import rv32m_pkg::*;
(
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   operand_i,
   input  logic [XLEN-1:0]   src_i,
   input  logic [CNT_W-1:0]  bit_idx,
   output logic [2*XLEN-1:0] acc_o,
   output logic              q_bit
);

   logic [2*XLEN-1:0] addend;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     divisor_ext;

   // Remainder needs one extra bit after the shift before the trial subtract.
   always_comb begin
      addend      = (2*XLEN)'(operand_i) << bit_idx;
      shifted     = {acc_i[XLEN-1:0], src_i[bit_idx]};
      divisor_ext = {1'b0, operand_i};
      q_bit       = 1'b0;
      if (is_div) begin
         q_bit = (shifted >= divisor_ext);
         acc_o = {{XLEN{1'b0}},
                  q_bit ? XLEN'(shifted - divisor_ext) : shifted[XLEN-1:0]};
      end else begin
         acc_o = src_i[bit_idx] ? (acc_i + addend) : acc_i;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   funct3     : RV32M operation select
//   rs1, rs2   : operands, captured on accept
//   flush      : abort the current operation, no done, result untouched
//   busy       : high while iterating (CALC/FIX)
//   done       : one-cycle pulse when result is updated
//   result     : operation result, held until the next completion
module muldiv_unit
   import rv32m_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic                neg_q, neg_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     quot_q, quot_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic                accept;
   logic                a_signed, b_signed, sa, sb;
   logic                in_is_div, in_is_rem;
   logic                div_zero, div_ovf;
   logic [XLEN-1:0]     special_res;
   logic [XLEN-1:0]     fix_res;
   logic [2*XLEN-1:0]   prod_fix;
   logic [2*XLEN-1:0]   step_acc;
   logic                step_q;
   logic [CNT_W-1:0]    step_idx;

   // Operand decode and special-case detection on the incoming request.
   always_comb begin
      a_signed  = 1'b0;
      b_signed  = 1'b0;
      case (funct3)
         F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         F3_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      sa          = a_signed & rs1[XLEN-1];
      sb          = b_signed & rs2[XLEN-1];
      in_is_div   = funct3[2];
      in_is_rem   = funct3[2] & funct3[1];
      div_zero    = in_is_div & (rs2 == '0);
      div_ovf     = in_is_div & ~funct3[0] & (rs1 == INT_MIN) & (rs2 == ALL_ONES);
      special_res = div_zero ? (in_is_rem ? rs1 : ALL_ONES)
                             : (in_is_rem ? '0  : INT_MIN);
      accept      = start & ~flush & ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   // Divide walks the dividend MSB first; multiply walks the multiplier LSB first.
   assign step_idx = op_q[2] ? ~cnt_q : cnt_q;

   muldiv_step u_step (
      .is_div    (op_q[2]),
      .acc_i     (acc_q),
      .operand_i (op_q[2] ? b_q : a_q),
      .src_i     (op_q[2] ? a_q : b_q),
      .bit_idx   (step_idx),
      .acc_o     (step_acc),
      .q_bit     (step_q)
   );

   // Sign correction and output selection applied in FIX.
   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      case (op_q)
         F3_MUL:                      fix_res = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             fix_res = neg_if(neg_q, quot_q);
         default:                     fix_res = neg_if(neg_q, acc_q[XLEN-1:0]);
      endcase
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      quot_d   = quot_q;
      result_d = result_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               op_d  = funct3;
               a_d   = neg_if(sa, rs1);
               b_d   = neg_if(sb, rs2);
               neg_d = in_is_rem ? sa : (sa ^ sb);
               if (div_zero || div_ovf) begin
                  state_d  = S_DONE;
                  result_d = special_res;
               end else begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  acc_d   = '0;
                  quot_d  = '0;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = step_acc;
               if (op_q[2]) quot_d = {quot_q[XLEN-2:0], step_q};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_res;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         quot_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         quot_q   <= quot_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for flush, reset, ignored start and back-to-back accepts.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp  = 0;
   int n_fail = 0;

   muldiv_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference results straight from the RV32M definition using 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: return (b == 0) ? a : 32'(sa % sb);
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   // Drive a one-cycle start; returns #1 after the sampling edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count edges (starting from lat0) until done is seen, bounded.
   task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
      lat = lat0;
      busy_cnt = 0;
      while (!done && lat < 80) begin
         busy_cnt += int'(busy);
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat, bc;
      issue(f, a, b);
      wait_done(1, lat, bc);
      check({name, " done"}, 32'(done), 32'd1);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, result, exp);
      check({name, " busy cycles"}, 32'(bc), (exp_lat == 1) ? 32'd0 : 32'd33);
      @(posedge clk); #1;
      check({name, " done pulse"}, 32'(done), 32'd0);
      check({name, " result hold"}, result, exp);
   endtask

   vec_t vecs[12];

   initial begin
      int          lat, bc;
      logic [2:0]  f;
      logic [31:0] a, b, last_res;
      logic        saw_done;

      vecs[0]  = '{"MUL neg",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{"MULH min*min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
      vecs[2]  = '{"MULHU max*max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[3]  = '{"MULHSU -1*max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      vecs[4]  = '{"DIV -7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      vecs[5]  = '{"REM -7/2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[6]  = '{"DIVU 100/7",    3'd5, 32'd100,        32'd7,         32'd14,        34};
      vecs[7]  = '{"REMU 100/7",    3'd7, 32'd100,        32'd7,         32'd2,         34};
      vecs[8]  = '{"DIVU x/0",      3'd5, 32'hDEAD_BEEF,  32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{"REM x/0",       3'd6, 32'h0000_1234,  32'd0,         32'h0000_1234, 1};
      vecs[10] = '{"DIV ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{"REM ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      check("reset busy",   32'(busy), 32'd0);
      check("reset done",   32'(done), 32'd0);
      check("reset result", result,    32'd0);
      rst_n = 1'b1;

      // Directed vectors
      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
            3: begin a = -32'($urandom_range(0, 255)); b = -32'($urandom_range(1, 15)); end
            default: ;
         endcase
         run_op($sformatf("rand%0d f%0d", i, f), f, a, b, ref_model(f, a, b), ref_lat(f, a, b));
      end

      // Known nonzero result before the flush test
      run_op("pre-flush MUL", 3'd0, 32'd6, 32'd7, 32'd42, 34);
      last_res = 32'd42;

      // Flush during CALC: no done, result untouched
      issue(3'd0, 32'd7, 32'd5);
      repeat (9) begin @(posedge clk); #1; end
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      saw_done = 1'b0;
      repeat (40) begin @(posedge clk); #1; saw_done |= done; end
      check("flush no done", 32'(saw_done), 32'd0);
      check("flush result kept", result, last_res);

      // Start during CALC is ignored
      issue(3'd5, 32'd100, 32'd7);
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk); start = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      wait_done(5, lat, bc);
      check("calc-start latency", 32'(lat), 32'd34);
      check("calc-start result", result, 32'd14);

      // Back-to-back: start in DONE is accepted with no IDLE bubble
      issue(3'd0, 32'd7, 32'hFFFF_FFFD);
      wait_done(1, lat, bc);
      check("b2b first result", result, 32'hFFFF_FFEB);
      start = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      check("b2b accept busy", 32'(busy), 32'd1);
      wait_done(1, lat, bc);
      check("b2b second latency", 32'(lat), 32'd34);
      check("b2b second result", result, 32'd14);
      check("b2b second busy cycles", 32'(bc), 32'd33);
      start = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0;
      @(posedge clk); #1; start = 1'b0;
      check("b2b special done", 32'(done), 32'd1);
      check("b2b special result", result, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      check("b2b special done drop", 32'(done), 32'd0);

      // flush and start together in IDLE: nothing accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd6; rs1 = 32'h55; rs2 = 32'd0;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      saw_done = done | busy;
      repeat (5) begin @(posedge clk); #1; saw_done |= done | busy; end
      check("flush+start no activity", 32'(saw_done), 32'd0);
      check("flush+start result", result, 32'hFFFF_FFFF);

      // Asynchronous reset mid-CALC
      issue(3'd0, 32'd3, 32'd5);
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk); #2; rst_n = 1'b0; #1;
      check("async reset busy",   32'(busy), 32'd0);
      check("async reset done",   32'(done), 32'd0);
      check("async reset result", result,    32'd0);
      @(negedge clk); rst_n = 1'b1;
      run_op("post-reset DIV", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
